// File: rtl/defines_package.sv
// Shared types and constants for the line rasterizer and the clip chain feeding it.
package defines_package;

  localparam int COORD_W   = 10;
  localparam int DELTA_W   = COORD_W + 2;
  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;

  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } Point2D;

  typedef struct packed {
    Point2D s;
    Point2D p;
  } Line2D;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW
  } raster_state_t;

endpackage

// File: rtl/raster_step.sv
// One Bresenham step: advances the current pixel and error term toward the line end.
module raster_step
  import defines_package::*;
(
  input  Point2D                    i_cur,
  input  logic signed [DELTA_W-1:0] i_err,
  input  logic signed [DELTA_W-1:0] i_dx,
  input  logic signed [DELTA_W-1:0] i_dy,
  input  logic                      i_sx_neg,
  input  logic                      i_sy_neg,
  output Point2D                    o_cur,
  output logic signed [DELTA_W-1:0] o_err
);

  logic signed [DELTA_W-1:0] w_e2;

  // 2*err stays within DELTA_W because |err| never exceeds the larger delta.
  assign w_e2 = i_err <<< 1;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    o_cur = i_cur;
    o_err = i_err;
    if (w_e2 >= i_dy) begin
      o_err   = o_err + i_dy;
      o_cur.x = i_sx_neg ? i_cur.x - COORD_ONE : i_cur.x + COORD_ONE;
    end
    if (w_e2 <= i_dx) begin
      o_err   = o_err + i_dx;
      o_cur.y = i_sy_neg ? i_cur.y - COORD_ONE : i_cur.y + COORD_ONE;
    end
  end

endmodule

// File: rtl/line_raster.sv
// Bresenham rasterizer: emits every pixel of an accepted clipped line, one per handshake.
// Optional LINE_RASTER_PIXEL_ADDR_EN builds the registered linear pixel address.
module line_raster
  import defines_package::*;
#(
  parameter int FB_STRIDE = FB_WIDTH,
  parameter int ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              n_rst,
  input  Line2D             line_in,
  input  logic              accept,
  input  logic              line_valid,
  output logic              line_ready,
  output Point2D            pix,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              busy,
  output logic              line_done
);

  if (FB_STRIDE < 1 || ADDR_W < 1) begin : g_param_check
    $error("line_raster: FB_STRIDE and ADDR_W must be positive");
  end

  raster_state_t             r_state, w_state_nxt;
  Point2D                    r_cur, r_end, w_next_cur;
  logic signed [DELTA_W-1:0] r_dx, r_dy, r_err, w_next_err;
  logic signed [DELTA_W-1:0] w_ddx, w_ddy;
  logic                      r_sx_neg, r_sy_neg;
  logic                      w_at_end, w_load, w_step;

  assign w_at_end = (r_cur == r_end);
  assign w_load   = (r_state == IDLE) && line_valid && accept;
  assign w_step   = pix_valid && pix_ready && !w_at_end;
  assign w_ddx    = $signed({2'b00, r_end.x}) - $signed({2'b00, r_cur.x});
  assign w_ddy    = $signed({2'b00, r_end.y}) - $signed({2'b00, r_cur.y});
  assign pix      = r_cur;

  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    line_ready  = 1'b0;
    busy        = 1'b1;
    pix_valid   = 1'b0;
    line_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        line_ready = 1'b1;
        busy       = 1'b0;
        if (line_valid && accept) w_state_nxt = SETUP;
      end
      SETUP: w_state_nxt = DRAW;
      DRAW: begin
        pix_valid = 1'b1;
        if (pix_ready && w_at_end) begin
          line_done   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  raster_step u_step (
    .i_cur    (r_cur),
    .i_err    (r_err),
    .i_dx     (r_dx),
    .i_dy     (r_dy),
    .i_sx_neg (r_sx_neg),
    .i_sy_neg (r_sy_neg),
    .o_cur    (w_next_cur),
    .o_err    (w_next_err)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cur    <= '0;
      r_end    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else if (w_load) begin
      r_cur <= line_in.s;
      r_end <= line_in.p;
    end else if (r_state == SETUP) begin
      r_dx     <= w_ddx[DELTA_W-1] ? -w_ddx : w_ddx;
      r_dy     <= w_ddy[DELTA_W-1] ? w_ddy : -w_ddy;
      r_err    <= (w_ddx[DELTA_W-1] ? -w_ddx : w_ddx) + (w_ddy[DELTA_W-1] ? w_ddy : -w_ddy);
      r_sx_neg <= !(r_end.x > r_cur.x);
      r_sy_neg <= !(r_end.y > r_cur.y);
    end else if (w_step) begin
      r_cur <= w_next_cur;
      r_err <= w_next_err;
    end
  end

`ifdef LINE_RASTER_PIXEL_ADDR_EN
  Point2D            w_addr_src;
  logic [ADDR_W-1:0] w_addr_nxt, r_pix_addr;

  // Address tracks whatever cur is about to become, so it lines up with pix.
  assign w_addr_src = w_load ? line_in.s : w_next_cur;
  assign w_addr_nxt = ADDR_W'(w_addr_src.y) * ADDR_W'(FB_STRIDE) + ADDR_W'(w_addr_src.x);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                r_pix_addr <= '0;
    else if (w_load || w_step) r_pix_addr <= w_addr_nxt;
  end

  assign pix_addr = r_pix_addr;
`else
  assign pix_addr = '0;
`endif

endmodule

// File: tb/tb_line_raster.sv
// Self-checking bench for line_raster: directed cases plus random lines against a queue-based reference.
module tb_line_raster;
  import defines_package::*;

  logic        clk = 1'b0;
  logic        n_rst;
  Line2D       line_in;
  logic        accept, line_valid, line_ready;
  Point2D      pix;
  logic        pix_valid, pix_ready;
  logic [18:0] pix_addr;
  logic        busy, line_done;

  int n_cmp = 0;
  int n_err = 0;
  Point2D exp_q[$];

  line_raster #(.FB_STRIDE(640), .ADDR_W(19)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .line_in    (line_in),
    .accept     (accept),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .pix        (pix),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_addr   (pix_addr),
    .busy       (busy),
    .line_done  (line_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic Point2D mk(input int x, input int y);
    Point2D p;
    p.x = COORD_W'(x);
    p.y = COORD_W'(y);
    return p;
  endfunction

  function automatic logic [31:0] exp_addr(input Point2D p);
`ifdef LINE_RASTER_PIXEL_ADDR_EN
    return (32'(p.y) * 32'd640 + 32'(p.x)) & 32'h7FFFF;
`else
    return 32'd0;
`endif
  endfunction

  // Reference pixel list from the integer Bresenham rule over the whole line.
  task automatic build_ref(input Point2D s, input Point2D p);
    int x = int'(s.x), y = int'(s.y), x1 = int'(p.x), y1 = int'(p.y);
    int dx = (x1 > x) ? x1 - x : x - x1;
    int dy = (y1 > y) ? y - y1 : y1 - y;
    int sx = (x1 > x) ? 1 : -1;
    int sy = (y1 > y) ? 1 : -1;
    int err = dx + dy;
    int e2;
    exp_q.delete();
    for (int guard = 0; guard < 4096; guard++) begin
      exp_q.push_back(mk(x, y));
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic offer(input Point2D s, input Point2D p, input bit acc);
    @(negedge clk);
    check("idle_line_ready", 32'(line_ready), 32'd1);
    line_in.s  = s;
    line_in.p  = p;
    accept     = acc;
    line_valid = 1'b1;
    @(negedge clk);
    line_valid = 1'b0;
    accept     = 1'b0;
  endtask

  task automatic run_line(input Point2D s, input Point2D p, input bit acc,
                          input int bp_pct, input int stall_idx, input int stall_len);
    int  idx = 0, stalled = 0, budget;
    bit  rdy;
    offer(s, p, acc);
    check("setup_pix_valid", 32'(pix_valid), 32'd0);
    check("setup_line_ready", 32'(line_ready), 32'(!acc));
    check("setup_busy", 32'(busy), 32'(acc));
    if (!acc) begin
      repeat (3) begin
        @(negedge clk);
        check("reject_pix_valid", 32'(pix_valid), 32'd0);
      end
      check("reject_line_ready", 32'(line_ready), 32'd1);
      return;
    end
    build_ref(s, p);
    budget = 20 * exp_q.size() + 50;
    while (idx < exp_q.size()) begin
      @(negedge clk);
      if (idx == stall_idx && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else begin
        rdy = ($urandom_range(99) >= bp_pct);
      end
      pix_ready = rdy;
      #1;
      check("draw_pix_valid", 32'(pix_valid), 32'd1);
      check("pix", 32'(pix), 32'(exp_q[idx]));
      check("pix_addr", 32'(pix_addr), exp_addr(exp_q[idx]));
      check("line_done", 32'(line_done), 32'(rdy && (idx == exp_q.size() - 1)));
      if (rdy) idx++;
      budget--;
      if (budget == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL draw_timeout: got %0d pixels expected %0d", idx, exp_q.size());
        break;
      end
    end
    @(negedge clk);
    pix_ready = 1'b0;
    #1;
    check("after_pix_valid", 32'(pix_valid), 32'd0);
    check("after_line_ready", 32'(line_ready), 32'd1);
    check("after_busy", 32'(busy), 32'd0);
    check("after_line_done", 32'(line_done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_line_ready"}, 32'(line_ready), 32'd1);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix"}, 32'(pix), 32'd0);
    check({tag, "_pix_addr"}, 32'(pix_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_line_done"}, 32'(line_done), 32'd0);
  endtask

  initial begin
    int range;
    Point2D s, p;
    n_rst      = 1'b0;
    line_in    = '0;
    accept     = 1'b0;
    line_valid = 1'b0;
    pix_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    n_rst = 1'b1;

    run_line(mk(0, 0), mk(3, 0), 1'b1, 0, -1, 0);
    run_line(mk(0, 0), mk(1, 3), 1'b1, 0, -1, 0);
    run_line(mk(5, 5), mk(2, 2), 1'b1, 0, -1, 0);
    run_line(mk(10, 10), mk(20, 20), 1'b0, 0, -1, 0);
    run_line(mk(7, 9), mk(7, 9), 1'b1, 0, -1, 0);
    run_line(mk(0, 0), mk(4, 0), 1'b1, 0, 2, 3);
    run_line(mk(1023, 0), mk(0, 1023), 1'b1, 0, -1, 0);

    // Abandon a line mid-draw with an asynchronous reset.
    offer(mk(0, 0), mk(5, 0), 1'b1);
    @(negedge clk);
    pix_ready = 1'b1;
    @(negedge clk);
    #1;
    check("pre_reset_pix", 32'(pix), 32'(mk(1, 0)));
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("midline_reset");
    pix_ready = 1'b0;
    @(negedge clk);
    check("held_reset_line_done", 32'(line_done), 32'd0);
    n_rst = 1'b1;
    run_line(mk(2, 3), mk(6, 1), 1'b1, 0, -1, 0);

    for (int i = 0; i < 40; i++) begin
      range = (i % 4 == 0) ? 1023 : 31;
      s = mk(int'($urandom_range(range)), int'($urandom_range(range)));
      p = mk(int'($urandom_range(range)), int'($urandom_range(range)));
      run_line(s, p, ($urandom_range(9) != 0), 30, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_raster.md
# line_raster

Bresenham line rasterizer sitting directly downstream of the Cohen-Sutherland clip chain. Accepts one clipped `Line2D` plus the chain's final `accept` flag and emits every pixel of the line, endpoint `s` to endpoint `p` inclusive, one per handshake, to the framebuffer writer. Rejected lines are consumed and dropped without producing pixels.

## Interface
- `FB_STRIDE`, default 640: framebuffer row pitch in pixels, used for `pix_addr`.
- `ADDR_W`, default 19: width of `pix_addr`.
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset. One clock domain; the polarity and synchronicity of this reset are fixed.
- `line_in`  in  `Line2D`  clipped line, with start point `.s` and end point `.p`.
- `accept`  in  1  clip verdict for `line_in`; 0 means drop the line.
- `line_valid`  in  1  `line_in` and `accept` are valid.
- `line_ready`  out  1  block can take a line.
- `pix`  out  `Point2D`  current pixel.
- `pix_valid`  out  1  `pix` (and `pix_addr`) are valid.
- `pix_ready`  in  1  consumer takes `pix` this cycle.
- `pix_addr`  out  `ADDR_W`  linear address, `pix.y*FB_STRIDE + pix.x`.
- `busy`  out  1  high whenever the state is not IDLE.
- `line_done`  out  1  one-cycle pulse on the final pixel handshake.

## Operation
- FSM states: IDLE, SETUP, DRAW.
- **IDLE**
  - `line_ready`=1.
  - On `line_valid & line_ready` with `accept`=0: consume the line and stay in IDLE. No pixels, no `line_done`.
  - With `accept`=1: latch `s`→cur and `p`→end, then go to SETUP.
- **SETUP**, one cycle. Compute:
  - dx = |end.x−cur.x|, dy = −|end.y−cur.y|.
  - sx = +1 if end.x > cur.x, else −1; sy likewise.
  - err = dx + dy.
  - Then go to DRAW.
- **DRAW**
  - `pix_valid`=1 and `pix`=cur.
  - On `pix_valid & pix_ready`:
    - If cur == end: pulse `line_done` and go to IDLE.
    - Otherwise, with e2 = 2·err: if e2 ≥ dy then err += dy and x += sx. If e2 ≤ dx then err += dx and y += sy. Both updates may apply in the same cycle.
- Widths:
  - Coordinates are unsigned `COORD_W` bits.
  - dx, dy, err and e2 are signed `COORD_W+2`, sized so that no overflow occurs.
  - `pix_addr` is truncated to `ADDR_W`.
- Degenerate line (s == p): exactly one pixel, then `line_done`.
- Pixel count is always max(|Δx|,|Δy|)+1.
- Backpressure: while `pix_ready`=0, `pix`, `pix_addr`, `pix_valid` and all internal state hold.

## Timing
- Reset values: state IDLE, `line_ready`=1, `pix_valid`=0, `pix`=0, `pix_addr`=0, `busy`=0, `line_done`=0.
- Accept handshake in cycle N → SETUP in N+1 → first `pix_valid` in N+2.
- Throughput is one pixel per cycle while `pix_ready`=1.
- `line_done` is asserted in the same cycle as the final pixel handshake.
- `line_ready` returns to 1 in the cycle after the final handshake. There is no overlap between lines.
- `line_ready` is 0 in SETUP and DRAW. `line_valid` is ignored there.
- `pix`/`pix_addr` are registered outputs, computed from the next cur.
- Reset mid-line abandons the line immediately. No further pixels and no `line_done`.

## Configuration
- Macro: `LINE_RASTER_PIXEL_ADDR_EN`.
- Defined: `pix_addr` is computed and registered as specified above.
- Undefined: the multiplier and adder are not built, and `pix_addr` is held at 0.
- All other behaviour is identical in both builds.

## Structure
- Shared package (`defines_package`) holds:
  - `Point2D` and `Line2D`.
  - `COORD_W`.
  - Enum `raster_state_t` {IDLE, SETUP, DRAW}.
  - Default FB dimensions (640×480).
- One natural sub-module: `raster_step`, combinational. Inputs: cur, err, dx, dy, sx, sy. Outputs: next cur and next err.
- FSM and registers live in `line_raster`.

## Test plan
- Horizontal line (0,0)→(3,0), `pix_ready`=1 → pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles. First pixel 2 cycles after the accept handshake. `line_done` with (3,0).
- Steep line (0,0)→(1,3) → pixels (0,0),(0,1),(1,2),(1,3).
- Reverse diagonal (5,5)→(2,2) → pixels (5,5),(4,4),(3,3),(2,2). With the address macro defined and `FB_STRIDE`=640, `pix_addr`=3205,2564,1923,1282.
- `accept`=0 on (10,10)→(20,20) → line consumed, `pix_valid` never asserts, `line_ready`=1 next cycle. Then degenerate line (7,9)→(7,9) → single pixel (7,9) with `line_done`.
- Backpressure on (0,0)→(4,0): drop `pix_ready` for 3 cycles while `pix`=(2,0) → `pix` holds (2,0) stable and the sequence continues (3,0),(4,0) with no loss or duplication.
- Assert `n_rst` while `pix`=(1,0) on (0,0)→(5,0) → outputs return to their reset values asynchronously, no `line_done`. A new line is accepted after release.
